// File: rtl/arm_imm_encoder.sv
// Iterative encoder from a 32-bit constant to the 12-bit shift_operand field:
// rotated 8-bit immediate search (one rotate index per cycle) or signed 12-bit offset check.
module arm_imm_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] value,
  input  logic        is_mem_command,
  output logic        busy,
  output logic        done,
  output logic        valid,
  output logic [11:0] shift_operand
);

  localparam int LEN_ADDRESS       = 32;
  localparam int LEN_SHIFT_OPERAND = 12;

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t                         state, state_nxt;
  logic [LEN_ADDRESS-1:0]         value_q;
  logic                           mem_q;
  logic [3:0]                     k;
  logic                           valid_q;
  logic [LEN_SHIFT_OPERAND-1:0]   so_q;
  logic [LEN_ADDRESS-1:0]         rot;
  logic                           imm_hit;
  logic                           mem_hit;
  logic                           accept;

  function automatic logic [LEN_ADDRESS-1:0] rotl(input logic [LEN_ADDRESS-1:0] x,
                                                   input logic [4:0] s);
    logic [2*LEN_ADDRESS-1:0] d;
    d = {x, x} << s;
    return d[2*LEN_ADDRESS-1:LEN_ADDRESS];
  endfunction

  assign accept  = start && (state != SEARCH);
  assign rot     = rotl(value_q, {k, 1'b0});
  assign imm_hit = (rot[31:8] == 24'd0);
  // Offset fits when bits 31..11 are a pure sign extension of bit 11.
  assign mem_hit = (&value_q[31:11]) | ~(|value_q[31:11]);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SEARCH;
      SEARCH:  if (mem_q || imm_hit || (k == 4'd15)) state_nxt = DONE;
      DONE:    state_nxt = start ? SEARCH : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      k       <= 4'd0;
      valid_q <= 1'b0;
      so_q    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        k       <= 4'd0;
        valid_q <= 1'b0;
        so_q    <= '0;
      end else if (state == SEARCH) begin
        if (mem_q) begin
          valid_q <= mem_hit;
          so_q    <= mem_hit ? value_q[11:0] : '0;
        end else if (imm_hit) begin
          valid_q <= 1'b1;
          so_q    <= {k, rot[7:0]};
        end else if (k == 4'd15) begin
          valid_q <= 1'b0;
          so_q    <= '0;
        end else begin
          k <= k + 4'd1;
        end
      end
    end
  end

  // Request operands are pure data; they only matter once a request is accepted.
  always_ff @(posedge clk) begin
    if (accept) begin
      value_q <= value;
      mem_q   <= is_mem_command;
    end
  end

  assign busy          = (state == SEARCH);
  assign done          = (state == DONE);
  assign valid         = valid_q;
  assign shift_operand = so_q;

endmodule

// File: tb/tb_arm_imm_encoder.sv
// Bench for arm_imm_encoder: brute-force encoding model plus per-cycle output comparison.
module tb_arm_imm_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] value = 32'd0;
  logic        is_mem_command = 1'b0;
  logic        busy, done, valid;
  logic [11:0] shift_operand;

  int n_tests = 0;
  int n_fail  = 0;

  arm_imm_encoder dut (
    .clk(clk), .rst(rst), .start(start), .value(value),
    .is_mem_command(is_mem_command), .busy(busy), .done(done),
    .valid(valid), .shift_operand(shift_operand)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ror32(input logic [31:0] x, input int s);
    if (s == 0) return x;
    return (x >> s) | (x << (32 - s));
  endfunction

  // Returns {valid, shift_operand}; lat is the cycle number of done.
  function automatic logic [12:0] model_enc(input logic [31:0] v, input logic m, output int lat);
    if (m) begin
      lat = 2;
      if ($signed(v) >= -2048 && $signed(v) <= 2047) return {1'b1, v[11:0]};
      return 13'd0;
    end
    for (int r = 0; r < 16; r++)
      for (int i = 0; i < 256; i++)
        if (ror32(i, 2 * r) == v) begin
          lat = r + 2;
          return {1'b1, r[3:0], i[7:0]};
        end
    lat = 17;
    return 13'd0;
  endfunction

  // Cycle-level expectation: phase 0 idle, 1 searching, 2 result cycle.
  int          m_phase = 0;
  int          m_rem   = 0;
  logic        m_valid = 1'b0;
  logic [11:0] m_so    = 12'd0;
  logic [12:0] m_res   = 13'd0;

  always @(posedge clk or posedge rst) begin
    int lat;
    if (rst) begin
      m_phase = 0; m_rem = 0; m_valid = 1'b0; m_so = 12'd0;
    end else if (m_phase != 1 && start) begin
      m_res   = model_enc(value, is_mem_command, lat);
      m_rem   = lat - 1;
      m_phase = 1; m_valid = 1'b0; m_so = 12'd0;
    end else if (m_phase == 1) begin
      m_rem--;
      if (m_rem == 0) begin
        m_phase = 2; m_valid = m_res[12]; m_so = m_res[11:0];
      end
    end else if (m_phase == 2) begin
      m_phase = 0;
    end
  end

  always @(negedge clk) begin
    chk("busy",          {31'd0, busy},  {31'd0, m_phase == 1});
    chk("done",          {31'd0, done},  {31'd0, m_phase == 2});
    chk("valid",         {31'd0, valid}, {31'd0, m_valid});
    chk("shift_operand", {20'd0, shift_operand}, {20'd0, m_so});
  end

  // Entered at a negedge; returns at the negedge of the done cycle.
  task automatic run(input logic [31:0] v, input logic m, input bit noise,
                     output int n, output logic vo, output logic [11:0] so);
    value = v; is_mem_command = m; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0; vo = 1'b0; so = 12'd0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (done) break;
      if (noise && busy) begin
        start = 1'b1; value = $urandom; is_mem_command = 1'($urandom_range(0, 1));
      end
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
    vo = valid; so = shift_operand;
  endtask

  task automatic dir(input string name, input logic [31:0] v, input logic m, input bit noise,
                     input int e_n, input logic e_v, input logic [11:0] e_so);
    int n; logic vo; logic [11:0] so;
    run(v, m, noise, n, vo, so);
    chk({name, "_latency"}, n, e_n);
    chk({name, "_valid"}, {31'd0, vo}, {31'd0, e_v});
    chk({name, "_so"}, {20'd0, so}, {20'd0, e_so});
  endtask

  initial begin
    int lat, n; logic vo; logic [11:0] so; logic [12:0] r;
    logic [31:0] v; logic m; int rr;

    // Pin the model against hand-computed encodings.
    r = model_enc(32'hFF000000, 1'b0, lat); chk("model_ff000000", {lat, 19'd0, r}, {32'd6, 19'd0, 13'h14FF});
    r = model_enc(32'h00000104, 1'b0, lat); chk("model_104", {19'd0, r}, {19'd0, 13'h1F41}); chk("model_104_lat", lat, 17);
    r = model_enc(32'h00000101, 1'b0, lat); chk("model_101", {19'd0, r}, 32'd0);
    r = model_enc(32'hFFFFF800, 1'b1, lat); chk("model_mem_neg", {19'd0, r}, {19'd0, 13'h1800});
    r = model_enc(32'h00000800, 1'b1, lat); chk("model_mem_800", {19'd0, r}, 32'd0);

    #1 rst = 1'b1;
    #1 chk("reset_outputs", {16'd0, busy, done, valid, 1'b0, shift_operand}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);

    dir("imm_ff",       32'h000000FF, 1'b0, 1'b0, 2,  1'b1, 12'h0FF);
    dir("imm_zero",     32'h00000000, 1'b0, 1'b0, 2,  1'b1, 12'h000);
    dir("imm_ff000000", 32'hFF000000, 1'b0, 1'b0, 6,  1'b1, 12'h4FF);
    dir("imm_104",      32'h00000104, 1'b0, 1'b0, 17, 1'b1, 12'hF41);
    dir("imm_101_miss", 32'h00000101, 1'b0, 1'b1, 17, 1'b0, 12'h000);
    dir("mem_neg",      32'hFFFFF800, 1'b1, 1'b0, 2,  1'b1, 12'h800);
    dir("mem_7ff",      32'h000007FF, 1'b1, 1'b0, 2,  1'b1, 12'h7FF);
    dir("mem_800",      32'h00000800, 1'b1, 1'b0, 2,  1'b0, 12'h000);

    // Back-to-back: start raised during the done cycle of a valid result.
    run(32'h000000FF, 1'b0, 1'b0, n, vo, so);
    value = 32'h00000101; is_mem_command = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("b2b_busy",  {31'd0, busy},  32'd1);
    chk("b2b_valid", {31'd0, valid}, 32'd0);
    chk("b2b_so",    {20'd0, shift_operand}, 32'd0);
    n = 1;
    while (!done && n < 40) begin @(negedge clk); n++; end
    chk("b2b_latency", n, 17);

    for (int i = 0; i < 1000; i++) begin
      m = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 1) == 1) begin
        rr = $urandom_range(0, 15);
        v  = ror32($urandom_range(0, 255), 2 * rr);
      end else begin
        v = $urandom;
      end
      if (m && $urandom_range(0, 1) == 1) v = {{21{v[11]}}, v[10:0]};
      run(v, m, 1'b0, n, vo, so);
      if (vo && !m) chk("rand_decode", ror32({24'd0, so[7:0]}, 2 * so[11:8]), v);
      if (vo && m)  chk("rand_mem_decode", {{20{so[11]}}, so}, v);
    end

    // Reset in cycle 5 of a miss search.
    @(negedge clk);
    @(negedge clk);
    value = 32'h00000101; is_mem_command = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1 chk("async_reset", {16'd0, busy, done, valid, 1'b0, shift_operand}, 32'd0);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    dir("post_reset", 32'hFF000000, 1'b0, 1'b0, 6, 1'b1, 12'h4FF);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/arm_imm_encoder.md
# arm_imm_encoder

Iterative encoder that converts a 32-bit constant into the 12-bit `shift_operand` field used by data-processing immediates and memory offsets. It performs the inverse of the Val2 decode. Data-processing mode searches for an 8-bit immediate plus 4-bit rotate. Memory mode checks for a signed 12-bit offset. It sits beside the instruction-fetch/patch path and the self-check testbench infrastructure, and is used to build instruction words from literal values.

## Interface
- No parameters; widths fixed by ISA: `LEN_ADDRESS` = 32, `LEN_SHIFT_OPERAND` = 12.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `start`  in  1  request pulse; sampled only while `busy`=0.
- `value`  in  32  constant to encode; captured on accepted `start`.
- `is_mem_command`  in  1  captured with `start`; 1 = 12-bit signed offset mode, 0 = rotated-immediate mode.
- `busy`  out  1  high while a request is being searched.
- `done`  out  1  one-cycle pulse when a result is ready.
- `valid`  out  1  result encodable; held until next accepted `start`.
- `shift_operand`  out  12  encoded field; held until next accepted `start`.

## Operation
- States: IDLE, SEARCH, DONE.
- IDLE, or DONE with `start`=1: latch `value` and mode, clear `valid`/`shift_operand`, set `k`=0, go to SEARCH.
- DONE with `start`=0: go to IDLE. `start` while in SEARCH is ignored.
- SEARCH, immediate mode, per cycle:
  - Test rotate index `k` (4-bit counter): t = rotate_left(value, 2k).
  - Hit if t[31:8] == 0. On hit: `shift_operand` = {k, t[7:0]}, `valid`=1, go to DONE.
  - Miss with `k`=15: `valid`=0, `shift_operand`=0, go to DONE. Otherwise increment `k`.
  - The smallest hitting `k` always wins. Decoding the result must reproduce ror(imm8, 2k) == value.
- SEARCH, memory mode, single cycle:
  - Hit if value[31:11] are all equal (sign-extension of bit 11). Then `shift_operand` = value[11:0], `valid`=1; else `valid`=0 and `shift_operand`=0.
  - Go to DONE.
- `done` = 1 exactly in state DONE. `busy` = 1 exactly in state SEARCH.
- Rotation arithmetic is modulo 32 on a 32-bit word. `k` wraps only via reset or a new request, never by overflow.

## Timing
- Reset (async, any state): state=IDLE, `k`=0, `busy`=0, `done`=0, `valid`=0, `shift_operand`=0. Outputs change immediately on `rst` assertion, not at the next edge.
- Reset mid-search aborts with no `done` pulse. The first `start` after `rst` deasserts is accepted normally.
- Cycle numbering: the cycle with accepted `start` is cycle 0.
- Immediate mode hit at index r: `busy` high in cycles 1..r+1; `done`, `valid`=1 and the result visible in cycle r+2.
- Immediate mode miss: `busy` high in cycles 1..16; `done` in cycle 17 with `valid`=0.
- Memory mode: `busy` in cycle 1; `done` in cycle 2.
- Back-to-back: `start` during the `done` cycle is accepted. `busy` rises the next cycle, and `valid`/`shift_operand` clear at that same edge.
- Outputs are registered; no combinational path from `value`/`start` to any output.

## Test plan
- Reset then `value`=0x000000FF, imm mode -> `done` in cycle 2, `valid`=1, `shift_operand`=0x0FF; `value`=0 -> `shift_operand`=0x000, cycle 2.
- `value`=0xFF000000 -> `done` cycle 6, `valid`=1, `shift_operand`=0x4FF; `value`=0x00000104 -> `done` cycle 17, `shift_operand`=0xF41.
- `value`=0x00000101 imm mode -> `busy` cycles 1..16, `done` cycle 17, `valid`=0, `shift_operand`=0x000; `start` pulses during `busy` have no effect.
- Memory mode: 0xFFFFF800 -> `done` cycle 2, `valid`=1, 0x800; 0x000007FF -> 0x7FF valid; 0x00000800 -> `valid`=0.
- Back-to-back: new `start` in a `done` cycle -> accepted, `busy` next cycle, previous `valid` cleared; random 32-bit values over 1000 runs: when `valid`=1, ror(imm8, 2·rot) equals `value` and rot is minimal; when `valid`=0, no rot 0..15 works.
- `rst` asserted in cycle 5 of a miss search -> all outputs 0 asynchronously, no `done`; a request after release completes with normal latency.
